// File: rtl/pipe_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl_if
//
// Purpose: bundles the hazard/stall signals exchanged between the 5-stage
// pipeline datapath and the central stall controller.
//
// Signals:
//   id_re1, id_re2     ID instruction reads source 1 / source 2
//   id_rs1, id_rs2     ID source register indices        [REG_AW-1:0]
//   ex_is_load         EX instruction is a load
//   ex_rd              EX destination register index     [REG_AW-1:0]
//   ex_is_div          EX instruction is a divide
//   ex_br_taken        branch/jump taken, resolved in EX
//   mem_wait           data memory not ready
//   pause              freeze bits [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB
//   bubble             load NOP into register i (same bit mapping as pause)
//   div_busy           divider sequencer active
//   div_done           one-cycle pulse on the divide's final cycle
//
// Modports:
//   master  pipeline side: drives the stall causes, receives the controls
//   slave   controller side: receives the causes, drives the controls
// ---------------------------------------------------------------------------
interface pipe_stall_ctrl_if #(
  parameter int REG_AW = 5
);

  logic              id_re1;
  logic              id_re2;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              ex_is_load;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_is_div;
  logic              ex_br_taken;
  logic              mem_wait;
  logic [4:0]        pause;
  logic [4:0]        bubble;
  logic              div_busy;
  logic              div_done;

  modport master (
    output id_re1, id_re2, id_rs1, id_rs2,
    output ex_is_load, ex_rd, ex_is_div, ex_br_taken, mem_wait,
    input  pause, bubble, div_busy, div_done
  );

  modport slave (
    input  id_re1, id_re2, id_rs1, id_rs2,
    input  ex_is_load, ex_rd, ex_is_div, ex_br_taken, mem_wait,
    output pause, bubble, div_busy, div_done
  );

endinterface

// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
//
// Purpose: central hazard and stall controller for a 5-stage pipeline
// (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It merges the stall causes from the
// stages (load-use in ID, multi-cycle divide in EX, memory wait in MEM,
// taken branch in EX) into a per-register pause vector and bubble vector,
// and owns the divide-latency sequencer so the pipeline registers only need
// plain pause/flush inputs.
//
// Parameters:
//   DIV_CYCLES  cycles a divide occupies EX (2..32), default 8
//   REG_AW      register index width, default 5
//
// Ports:
//   clk    clock
//   rst    synchronous, active-low reset; all outputs forced 0 while low
//   bus    pipe_stall_ctrl_if.slave (stall causes in, pause/bubble/div out)
//
// Optional build macro PIPE_STALL_PERF_EN adds:
//   stall_cycles [31:0]  cycles with the PC frozen (pause[0]=1)
//   flush_count  [15:0]  applied branch flushes
// Both wrap and clear on reset. Without the macro they do not exist.
// ---------------------------------------------------------------------------
module pipe_stall_ctrl #(
  parameter int DIV_CYCLES = 8,
  parameter int REG_AW     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_stall_ctrl_if.slave     bus
`ifdef PIPE_STALL_PERF_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [15:0]          flush_count
`endif
);

  localparam int CW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  // Stall patterns for stage k stalling: pause[k:0], bubble[k+1].
  localparam logic [4:0] MEM_PAUSE  = 5'b01111;
  localparam logic [4:0] MEM_BUBBLE = 5'b10000;
  localparam logic [4:0] DIV_PAUSE  = 5'b00111;
  localparam logic [4:0] DIV_BUBBLE = 5'b01000;
  localparam logic [4:0] LU_PAUSE   = 5'b00011;
  localparam logic [4:0] LU_BUBBLE  = 5'b00100;
  localparam logic [4:0] BR_BUBBLE  = 5'b00110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  div_state_t    state;
  logic [CW-1:0] cnt;
  logic          done_q;

  logic       luse;
  logic       div_stall;
  logic       flush;
  logic [4:0] pause_c;
  logic [4:0] bubble_c;
  logic [4:0] pause_o;

  // Divide sequencer. The launch cycle in IDLE already stalls EX, so cnt
  // holds the number of BUSY cycles still to go (including the current
  // one); the last productive BUSY cycle is cnt==1. Together with the
  // launch cycle and the DONE cycle this keeps the divide in EX for exactly
  // DIV_CYCLES cycles. mem_wait freezes all progress. done_q is the
  // registered div_done flag, high exactly while in DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ex_is_div && !bus.mem_wait) begin
            if (DIV_CYCLES <= 2) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= BUSY;
              cnt   <= CW'(DIV_CYCLES - 2);
            end
          end
        end
        BUSY: begin
          if (!bus.mem_wait) begin
            if (cnt == CW'(1)) begin
              state  <= DONE;
              cnt    <= '0;
              done_q <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        DONE: begin
          // ex_is_div is still high here for the same instruction; ignoring
          // it prevents the finished divide from relaunching.
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // Load-use hazard: the load in EX writes a register the ID instruction
  // reads. Register 0 is hardwired, so it never creates a hazard.
  always_comb begin
    luse = bus.ex_is_load && (bus.ex_rd != ZERO_REG) &&
           ((bus.id_re1 && (bus.id_rs1 == bus.ex_rd)) ||
            (bus.id_re2 && (bus.id_rs2 == bus.ex_rd)));
  end

  // EX is held by the divider in BUSY and on the launch cycle in IDLE.
  always_comb begin
    div_stall = (state == BUSY) || ((state == IDLE) && bus.ex_is_div);
  end

  // Cause arbitration. A taken branch only flushes when EX is free to move
  // (no mem or divide stall); otherwise the branch simply waits in EX with
  // ex_br_taken held and the flush lands on the release cycle. The flush
  // beats a load-use stall because the ID instruction is being cancelled.
  always_comb begin
    pause_c  = '0;
    bubble_c = '0;
    flush    = 1'b0;
    if (bus.mem_wait) begin
      pause_c  = MEM_PAUSE;
      bubble_c = MEM_BUBBLE;
    end else if (div_stall) begin
      pause_c  = DIV_PAUSE;
      bubble_c = DIV_BUBBLE;
    end else if (bus.ex_br_taken) begin
      bubble_c = BR_BUBBLE;
      flush    = 1'b1;
    end else if (luse) begin
      pause_c  = LU_PAUSE;
      bubble_c = LU_BUBBLE;
    end
  end

  // Outputs are forced low while reset is held. A frozen register must not
  // also be loaded with a NOP, so pause masks bubble bit-for-bit.
  always_comb begin
    pause_o = rst ? pause_c : 5'b00000;
  end

  assign bus.pause    = pause_o;
  assign bus.bubble   = rst ? (bubble_c & ~pause_c) : 5'b00000;
  assign bus.div_busy = rst & div_stall;
  assign bus.div_done = rst & done_q;

`ifdef PIPE_STALL_PERF_EN
  // Performance counters, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (pause_o[0]) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (flush) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_stall_ctrl
//
// Purpose: self-checking bench for pipe_stall_ctrl. A behavioural model
// tracks how many productive cycles the current divide has spent in EX and
// derives the expected outputs from the stall priority rules every cycle;
// directed vectors with hand-computed literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

  localparam int DIV = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pipe_stall_ctrl_if #(.REG_AW(5)) bus();

`ifdef PIPE_STALL_PERF_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  pipe_stall_ctrl #(
    .DIV_CYCLES(DIV),
    .REG_AW(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef PIPE_STALL_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: productive (non-mem_wait) cycles the current divide has
  // already spent in EX; 0 means no divide in progress.
  int progress      = 0;
  int progress_next = 0;
  int m_stalls      = 0;
  int m_stalls_next = 0;
  int m_flushes     = 0;
  int m_flush_next  = 0;

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin : compare
    logic       luse, done_now, divst, fl;
    logic [4:0] ep, eb;
    logic       ebusy, edone;
    luse = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
           ((bus.id_re1 && bus.id_rs1 == bus.ex_rd) ||
            (bus.id_re2 && bus.id_rs2 == bus.ex_rd));
    done_now = (progress == DIV - 1);
    divst    = (progress == 0 && bus.ex_is_div) || (progress > 0 && !done_now);
    ep = 5'b0; eb = 5'b0; fl = 1'b0;
    if (rst) begin
      if (bus.mem_wait) begin ep = 5'b01111; eb = 5'b10000; end
      else if (divst)   begin ep = 5'b00111; eb = 5'b01000; end
      else if (bus.ex_br_taken) begin eb = 5'b00110; fl = 1'b1; end
      else if (luse)    begin ep = 5'b00011; eb = 5'b00100; end
    end
    ebusy = rst && divst;
    edone = rst && done_now;

    checks++;
    if (bus.pause !== ep) begin
      failures++;
      $display("[TB] FAIL model_pause t=%0t got=%b exp=%b", $time, bus.pause, ep);
    end
    checks++;
    if (bus.bubble !== eb) begin
      failures++;
      $display("[TB] FAIL model_bubble t=%0t got=%b exp=%b", $time, bus.bubble, eb);
    end
    checks++;
    if (bus.div_busy !== ebusy || bus.div_done !== edone) begin
      failures++;
      $display("[TB] FAIL model_div t=%0t got busy=%b done=%b exp busy=%b done=%b",
               $time, bus.div_busy, bus.div_done, ebusy, edone);
    end
`ifdef PIPE_STALL_PERF_EN
    checks++;
    if (stall_cycles !== 32'(m_stalls) || flush_count !== 16'(m_flushes)) begin
      failures++;
      $display("[TB] FAIL model_perf t=%0t got stalls=%0d flushes=%0d exp stalls=%0d flushes=%0d",
               $time, stall_cycles, flush_count, m_stalls, m_flushes);
    end
`endif

    if (!rst) begin
      progress_next = 0;
      m_stalls_next = 0;
      m_flush_next  = 0;
    end else begin
      if (done_now) progress_next = 0;
      else if (divst && !bus.mem_wait) progress_next = progress + 1;
      else progress_next = progress;
      m_stalls_next = m_stalls + (ep[0] ? 1 : 0);
      m_flush_next  = m_flushes + (fl ? 1 : 0);
    end
  end

  always @(posedge clk) begin
    progress  = progress_next;
    m_stalls  = m_stalls_next;
    m_flushes = m_flush_next;
  end

  // Drive one cycle of inputs shortly after the active edge.
  task automatic applyStimulus(input logic r, input logic re1, input logic [4:0] rs1,
                               input logic re2, input logic [4:0] rs2,
                               input logic ld, input logic [4:0] rd,
                               input logic dv, input logic br, input logic mw);
    @(posedge clk);
    #1;
    rst             = r;
    bus.id_re1      = re1;
    bus.id_rs1      = rs1;
    bus.id_re2      = re2;
    bus.id_rs2      = rs2;
    bus.ex_is_load  = ld;
    bus.ex_rd       = rd;
    bus.ex_is_div   = dv;
    bus.ex_br_taken = br;
    bus.mem_wait    = mw;
  endtask

  // Hand-computed literal expectation for the current cycle.
  task automatic checkOutput(input string name, input logic [4:0] ep, input logic [4:0] eb,
                             input logic ebusy, input logic edone);
    @(negedge clk);
    checks++;
    if (bus.pause !== ep || bus.bubble !== eb ||
        bus.div_busy !== ebusy || bus.div_done !== edone) begin
      failures++;
      $display("[TB] FAIL %s got p=%b b=%b busy=%b done=%b exp p=%b b=%b busy=%b done=%b",
               name, bus.pause, bus.bubble, bus.div_busy, bus.div_done,
               ep, eb, ebusy, edone);
    end
  endtask

  initial begin
    bus.id_re1 = 0; bus.id_rs1 = 0; bus.id_re2 = 0; bus.id_rs2 = 0;
    bus.ex_is_load = 0; bus.ex_rd = 0; bus.ex_is_div = 0;
    bus.ex_br_taken = 0; bus.mem_wait = 0;

    // Reset with causes active: everything forced low.
    applyStimulus(0, 1, 5, 0, 0, 1, 5, 1, 1, 1);
    checkOutput("reset_forced", 5'b0, 5'b0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("idle", 5'b0, 5'b0, 0, 0);

    // Load-use hazards.
    applyStimulus(1, 1, 5, 0, 0, 1, 5, 0, 0, 0);
    checkOutput("luse_rs1", 5'b00011, 5'b00100, 0, 0);
    applyStimulus(1, 0, 5, 1, 5, 1, 5, 0, 0, 0);
    checkOutput("luse_rs2", 5'b00011, 5'b00100, 0, 0);
    applyStimulus(1, 0, 5, 0, 5, 1, 5, 0, 0, 0);
    checkOutput("luse_no_read", 5'b0, 5'b0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("luse_rd0", 5'b0, 5'b0, 0, 0);

    // Divide held: 7 stall cycles, done on cycle 8.
    for (int i = 0; i < DIV - 1; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput("div_stall", 5'b00111, 5'b01000, 1, 0);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("div_done", 5'b0, 5'b0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("div_after", 5'b0, 5'b0, 0, 0);

    // Divide with 3 mem_wait cycles after 3 stall cycles: done on cycle 11.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput("divmw_pre", 5'b00111, 5'b01000, 1, 0);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      checkOutput("divmw_wait", 5'b01111, 5'b10000, 1, 0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput("divmw_post", 5'b00111, 5'b01000, 1, 0);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("divmw_done", 5'b0, 5'b0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Branch flush cases.
    applyStimulus(1, 1, 7, 0, 0, 1, 7, 0, 1, 0);
    checkOutput("br_over_luse", 5'b0, 5'b00110, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("br_alone", 5'b0, 5'b00110, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("br_under_mem", 5'b01111, 5'b10000, 0, 0);

    // Branch held through a divide: flush lands when EX is released.
    for (int i = 0; i < DIV - 1; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      checkOutput("br_div_stall", 5'b00111, 5'b01000, 1, 0);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    checkOutput("br_div_release", 5'b0, 5'b00110, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("br_div_after", 5'b0, 5'b0, 0, 0);

    // Reset mid-BUSY (3 BUSY cycles left), then a full fresh divide.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("rst_mid_div", 5'b0, 5'b0, 0, 0);
    for (int i = 0; i < DIV - 1; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput("rst_restart", 5'b00111, 5'b01000, 1, 0);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("rst_restart_done", 5'b0, 5'b0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("final_idle", 5'b0, 5'b0, 0, 0);

`ifdef PIPE_STALL_PERF_EN
    // Counters after a reset: 1 load-use + 1 divide + 1 flush.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 3, 0, 0, 1, 3, 0, 0, 0);
    for (int i = 0; i < DIV; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (stall_cycles !== 32'd8 || flush_count !== 16'd1) begin
      failures++;
      $display("[TB] FAIL perf_literal got stalls=%0d flushes=%0d exp stalls=8 flushes=1",
               stall_cycles, flush_count);
    end
`endif

    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
